// File: rtl/instrucoes_loader_if.sv
// instrucoes_loader_if: byte stream in and instruction RAM write port out of the loader
interface instrucoes_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] endereco_escrita;
  logic [DATA_WIDTH-1:0] dado;
  modport master (
    input  byte_in, byte_valid,
    output byte_ready, we, endereco_escrita, dado
  );
  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, we, endereco_escrita, dado
  );
endinterface

// File: rtl/instrucoes_loader.sv
// instrucoes_loader: packs a byte stream MSB-first into words and writes them to instruction RAM
module instrucoes_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  write_clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  instrucoes_loader_if.master   bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FIN} state_t;
  localparam logic [ADDR_WIDTH:0] LIMIT = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t                state, state_nx;
  logic [ADDR_WIDTH:0]   count, idx, idx_inc;
  logic [1:0]            bidx;
  logic [DATA_WIDTH-9:0] shift;
  logic                  xfer, bad;
  assign xfer    = state == LOAD && bus.byte_valid;
  assign bad     = word_count == '0 || word_count > LIMIT;
  assign idx_inc = idx + 1'b1;
  assign bus.byte_ready = state == LOAD;
  assign bus.we         = state == WRITE;
  assign cpu_hold       = state == LOAD || state == WRITE;
  assign done           = state == FIN;
  always_ff @(posedge write_clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (bad ? FIN : LOAD) : IDLE;
      LOAD:    state_nx = xfer && bidx == 2'd3 ? WRITE : LOAD;
      WRITE:   state_nx = idx_inc == count ? FIN : LOAD;
      default: state_nx = IDLE;
    endcase
  end
  // dado/endereco_escrita are loaded on the edge entering WRITE and held otherwise
  always_ff @(posedge write_clock or negedge reset_n)
    if (!reset_n) begin
      count                <= '0;
      idx                  <= '0;
      bidx                 <= '0;
      shift                <= '0;
      error                <= 1'b0;
      checksum             <= '0;
      bus.dado             <= '0;
      bus.endereco_escrita <= '0;
    end else begin
      if (state == IDLE && start) begin
        count    <= word_count;
        idx      <= '0;
        bidx     <= '0;
        error    <= bad;
        checksum <= '0;
      end
      if (xfer) begin
        bidx  <= bidx + 1'b1;
        shift <= {shift[DATA_WIDTH-17:0], bus.byte_in};
        if (bidx == 2'd3) begin
          bus.dado             <= {shift, bus.byte_in};
          bus.endereco_escrita <= idx[ADDR_WIDTH-1:0];
        end
      end
      if (state == WRITE) begin
        checksum <= checksum ^ bus.dado;
        idx      <= idx_inc;
      end
    end
endmodule

// File: tb/tb_instrucoes_loader.sv
// tb_instrucoes_loader: directed checks of the instruction loader with immediate assertions
module tb_instrucoes_loader;
  logic        write_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] word_count = '0;
  logic        cpu_hold, done, error;
  logic [31:0] checksum;
  int          vectors = 0;
  int          miscompares = 0;
  int          hold_cnt = 0;
  logic [10:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] model_sum;

  instrucoes_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus ();

  instrucoes_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) dut (
    .write_clock(write_clock),
    .reset_n(reset_n),
    .start(start),
    .word_count(word_count),
    .bus(bus.master),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .checksum(checksum)
  );

  always #5 write_clock = ~write_clock;

  always @(negedge write_clock) begin
    if (bus.we) begin
      wr_addr.push_back(bus.endereco_escrita);
      wr_data.push_back(bus.dado);
    end
    if (cpu_hold) hold_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge write_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.byte_ready; i++) tick();
    if (!bus.byte_ready) chk("byte_ready timeout", bus.byte_ready, 1);
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      for (int g = $urandom_range(0, max_gap); g > 0; g--) tick();
      send_byte(w[31-8*k -: 8]);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) tick();
    chk("done pulse", done, 1);
  endtask

  task automatic do_start(input logic [11:0] n);
    start = 1'b1;
    word_count = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    #12;
    chk("rst byte_ready", bus.byte_ready, 0);
    chk("rst we", bus.we, 0);
    chk("rst dado", bus.dado, 0);
    chk("rst hold/done/err", {cpu_hold, done, error}, 0);
    reset_n = 1'b1;
    tick();

    // 1: single word back-to-back
    do_start(12'd1);
    chk("t1 cpu_hold", cpu_hold, 1);
    send_word(32'h04200001, 0);
    chk("t1 we", bus.we, 1);
    chk("t1 addr", bus.endereco_escrita, 0);
    chk("t1 dado", bus.dado, 32'h04200001);
    tick();
    chk("t1 done", done, 1);
    chk("t1 hold in FIN", cpu_hold, 0);
    chk("t1 checksum", checksum, 32'h04200001);
    tick();
    chk("t1 done one cycle", done, 0);
    chk("t1 addr held", bus.endereco_escrita, 0);
    chk("t1 writes", wr_data.size(), 1);

    // 2: three words with random gaps
    wr_addr.delete(); wr_data.delete();
    do_start(12'd3);
    send_word(32'h11111111, 3);
    send_word(32'h22222222, 3);
    send_word(32'h44444444, 3);
    wait_done();
    chk("t2 checksum", checksum, 32'h77777777);
    chk("t2 error", error, 0);
    chk("t2 writes", wr_data.size(), 3);
    chk("t2 w0", {wr_addr[0], wr_data[0]}, {11'd0, 32'h11111111});
    chk("t2 w1", {wr_addr[1], wr_data[1]}, {11'd1, 32'h22222222});
    chk("t2 w2", {wr_addr[2], wr_data[2]}, {11'd2, 32'h44444444});
    tick();

    // 3: illegal counts
    wr_addr.delete(); wr_data.delete();
    do_start(12'd0);
    chk("t3 zero done/err", {done, error, bus.we, cpu_hold}, 4'b1100);
    tick();
    chk("t3 zero sticky", {done, error}, 2'b01);
    do_start(12'd2049);
    chk("t3 2049 done/err", {done, error, bus.we, cpu_hold}, 4'b1100);
    tick();
    chk("t3 no writes", wr_data.size(), 0);
    do_start(12'd1);
    chk("t3 error cleared", error, 0);
    send_word(32'hDEADBEEF, 0);
    wait_done();
    chk("t3 ok checksum/err", {checksum, error}, {32'hDEADBEEF, 1'b0});
    tick();

    // 4: reset in the middle of the second word
    wr_addr.delete(); wr_data.delete();
    do_start(12'd2);
    send_word(32'h01020304, 0);
    send_byte(8'h05);
    send_byte(8'h06);
    #2 reset_n = 1'b0;
    #1;
    chk("t4 rst outs", {bus.byte_ready, bus.we, cpu_hold, done, error}, 0);
    chk("t4 rst dado/sum", {bus.dado, checksum}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t4 idle after rst", {bus.byte_ready, cpu_hold}, 0);
    chk("t4 writes before rst", wr_data.size(), 1);
    do_start(12'd1);
    send_word(32'hAABBCCDD, 0);
    chk("t4 restart write", {bus.we, bus.endereco_escrita, bus.dado}, {1'b1, 11'd0, 32'hAABBCCDD});
    wait_done();
    tick();

    // 6: byte held valid across WRITE becomes byte 0 of next word
    wr_addr.delete(); wr_data.delete();
    do_start(12'd2);
    send_word(32'h01020304, 0);
    bus.byte_in = 8'h55;
    bus.byte_valid = 1'b1;
    chk("t6 write cycle ready", {bus.we, bus.byte_ready}, 2'b10);
    tick();
    chk("t6 load ready", {bus.we, bus.byte_ready}, 2'b01);
    tick();
    bus.byte_valid = 1'b0;
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    chk("t6 second word", bus.dado, 32'h55667788);
    wait_done();
    chk("t6 writes", wr_data.size(), 2);
    chk("t6 checksum", checksum, 32'h01020304 ^ 32'h55667788);
    tick();

    // 5: full 2048-word load with a stray start during LOAD
    wr_addr.delete(); wr_data.delete();
    model_sum = '0;
    hold_cnt = 0;
    do_start(12'd2048);
    for (int i = 0; i < 2048; i++) begin
      if (i == 5) begin
        start = 1'b1;
        word_count = 12'd1;
      end
      send_word(32'hC0DE0000 | i, 0);
      start = 1'b0;
      model_sum ^= 32'hC0DE0000 | i;
    end
    chk("t5 last we", {bus.we, bus.endereco_escrita}, {1'b1, 11'd2047});
    tick();
    chk("t5 done", done, 1);
    chk("t5 hold cycles", hold_cnt, 2048 * 5);
    chk("t5 writes", wr_data.size(), 2048);
    chk("t5 last addr", wr_addr[2047], 11'd2047);
    chk("t5 word 5", wr_data[5], 32'hC0DE0005);
    chk("t5 checksum", checksum, model_sum);
    chk("t5 error", error, 0);
    tick();
    chk("t5 idle", {done, cpu_hold, bus.endereco_escrita}, {2'b00, 11'd2047});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
